// File: rtl/mxv_row_scheduler.sv
// Row-by-row sequencer for a matrix-vector product A*p on a shared dot-product engine.
// Streams masked row/vector chunks to the engine and writes each row result to AP memory.
module mxv_row_scheduler #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 12
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [31:0]                            total,
  input  logic [31:0]                            no_of_rows,
  output logic [addr_width-1:0]                  row_mem_addr,
  input  logic [element_width*no_of_units-1:0]   row_mem_rdata,
  output logic [addr_width-1:0]                  vec_mem_addr,
  input  logic [element_width*no_of_units-1:0]   vec_mem_rdata,
  output logic                                   dp_clear,
  output logic                                   dp_valid,
  output logic                                   dp_last,
  output logic [element_width*no_of_units-1:0]   dp_a,
  output logic [element_width*no_of_units-1:0]   dp_b,
  input  logic [element_width-1:0]               dp_result,
  input  logic                                   dp_finish,
  output logic                                   ap_we,
  output logic [addr_width-1:0]                  ap_addr,
  output logic [element_width-1:0]              ap_wdata,
  output logic                                   busy,
  output logic                                   done
);

  localparam logic [31:0] units = 32'(no_of_units);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    WRITE,
    FIN
  } state_t;

  state_t state, next_state;

  logic [31:0]              chunks_q;
  logic [31:0]              rem_q;
  logic [31:0]              rows_q;
  logic [31:0]              chunk;
  logic [31:0]              row;
  logic [addr_width-1:0]    rb;
  logic [element_width-1:0] result_q;
  logic                     valid_d;
  logic                     last_d;
  logic                     trivial;
  logic                     last_issue;
  logic                     last_row;

  assign trivial    = (total == 32'd0) || (no_of_rows == 32'd0);
  assign last_issue = (chunk == chunks_q - 32'd1);
  assign last_row   = (row == rows_q - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    row_mem_addr = '0;
    vec_mem_addr = '0;
    dp_clear     = 1'b0;
    ap_we        = 1'b0;
    ap_addr      = '0;
    ap_wdata     = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        // An empty job completes through FIN without ever raising busy.
        if (start) next_state = trivial ? FIN : CLEAR;
      end
      CLEAR: begin
        busy       = 1'b1;
        dp_clear   = 1'b1;
        next_state = ISSUE;
      end
      ISSUE: begin
        busy         = 1'b1;
        row_mem_addr = rb + chunk[addr_width-1:0];
        vec_mem_addr = chunk[addr_width-1:0];
        if (last_issue) next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (dp_finish) next_state = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        ap_we      = 1'b1;
        ap_addr    = row[addr_width-1:0];
        ap_wdata   = result_q;
        next_state = last_row ? FIN : CLEAR;
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chunks_q <= '0;
      rem_q    <= '0;
      rows_q   <= '0;
      chunk    <= '0;
      row      <= '0;
      rb       <= '0;
      result_q <= '0;
      valid_d  <= 1'b0;
      last_d   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !trivial) begin
            chunks_q <= (total / units) + {31'd0, |(total % units)};
            rem_q    <= total % units;
            rows_q   <= no_of_rows;
            row      <= '0;
            rb       <= '0;
          end
        end
        CLEAR: chunk <= '0;
        ISSUE: chunk <= chunk + 32'd1;
        DRAIN: if (dp_finish) result_q <= dp_result;
        WRITE: begin
          rb  <= rb + chunks_q[addr_width-1:0];
          row <= row + 32'd1;
        end
        default: ;
      endcase
      // Memory data arrives one cycle after its address, so valid/last trail the issue.
      valid_d <= (state == ISSUE);
      last_d  <= (state == ISSUE) && last_issue;
    end
  end

  always_comb begin
    dp_valid = valid_d;
    dp_last  = last_d;
    dp_a     = '0;
    dp_b     = '0;
    if (valid_d) begin
      for (int i = 0; i < no_of_units; i++) begin
        // Lanes past the row length in the final chunk must not contribute.
        if (last_d && (rem_q != 32'd0) && (32'(i) >= rem_q)) begin
          dp_a[i*element_width +: element_width] = '0;
          dp_b[i*element_width +: element_width] = '0;
        end else begin
          dp_a[i*element_width +: element_width] = row_mem_rdata[i*element_width +: element_width];
          dp_b[i*element_width +: element_width] = vec_mem_rdata[i*element_width +: element_width];
        end
      end
    end
  end

endmodule
